// File: rtl/frame_pkg.sv
// Shared definitions for the OOK frame path: framing constants and the
// scheduler state encoding, common to generator, scheduler and checkers.
package frame_pkg;

  // Comma + head + tail words wrapped around the PRBS payload.
  localparam int FRAME_OVERHEAD = 3;

  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] COMMA = 16'hBC50;
  localparam logic [WORD_WIDTH-1:0] HEAD  = 16'hA5C3;
  localparam logic [WORD_WIDTH-1:0] TAIL  = 16'h3C5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FRAME = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  function automatic int frame_words(input int prbs_length);
    return prbs_length + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/frame_scheduler.sv
// Launches bursts (or a continuous stream) of fixed-length frames on the PRBS
// frame generator, with a programmable idle gap between frames.
module frame_scheduler
  import frame_pkg::*;
#(
  parameter int PRBS_LENGTH = 8,
  parameter int GAP_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] frame_count,
  input  logic [GAP_WIDTH-1:0] gap_len,
  output logic                 send_enable,
  output logic                 frame_active,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  localparam int FRAME_WORDS = frame_words(PRBS_LENGTH);
  localparam int WCNT_W      = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

  sched_state_t         state;
  logic [WCNT_W-1:0]    word_cnt;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 stop_pending;
  logic                 cont_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [GAP_WIDTH-1:0] gap_reg;

  logic                 last_word;
  logic                 gap_last;
  logic [CNT_WIDTH-1:0] sent_next;
  logic                 burst_end;

  assign last_word = (word_cnt == WCNT_W'(FRAME_WORDS - 1));
  assign gap_last  = (gap_cnt == gap_reg - GAP_WIDTH'(1));
  assign sent_next = frames_sent + CNT_WIDTH'(1);
  // A stop arriving on the final word still counts: the next frame is not yet committed.
  assign burst_end = stop_pending || stop || (!cont_reg && (sent_next == count_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      cont_reg     <= 1'b0;
      count_reg    <= '0;
      gap_reg      <= '0;
      send_enable  <= 1'b0;
      frame_active <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frames_sent  <= '0;
    end else begin
      send_enable <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (continuous || (frame_count != '0))) begin
            cont_reg     <= continuous;
            count_reg    <= frame_count;
            gap_reg      <= gap_len;
            frames_sent  <= '0;
            stop_pending <= 1'b0;
            send_enable  <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          if (stop) stop_pending <= 1'b1;
          word_cnt     <= '0;
          frame_active <= 1'b1;
          state        <= FRAME;
        end

        FRAME: begin
          if (stop) stop_pending <= 1'b1;
          if (last_word) begin
            frame_active <= 1'b0;
            frames_sent  <= sent_next;
            if (burst_end) begin
              stop_pending <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end else if (gap_reg == '0) begin
              send_enable <= 1'b1;
              state       <= ISSUE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else begin
            word_cnt <= word_cnt + WCNT_W'(1);
          end
        end

        GAP: begin
          if (stop_pending || stop) begin
            stop_pending <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end else if (gap_last) begin
            send_enable <= 1'b1;
            state       <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GAP_WIDTH'(1);
          end
        end

        default: begin
          frame_active <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
